// File: rtl/fmap_pkg.sv
// Shared definitions for the feature-map capture path and the display tiler:
// map count, fixed BRAM layout (base address and pixel count per map id)
// and the capture FSM state encoding.
package fmap_pkg;

    localparam int NM     = 22;
    localparam int ADDR_W = 16;
    localparam int IDX_W  = 10;
    localparam int ID_W   = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } capture_state_t;

    // Base BRAM address of a map; ids outside the table return 0.
    function automatic logic [ADDR_W-1:0] map_base(input logic [ID_W-1:0] id);
        logic [ADDR_W-1:0] off;
        off = '0;
        if (id == 5'd0) begin
            return 16'h0000;
        end else if (id <= 5'd16) begin
            off = ADDR_W'(id) - 16'd1;
            return 16'h0320 + off * 16'h0240;
        end else if (id <= 5'd20) begin
            off = ADDR_W'(id) - 16'd17;
            return 16'h2720 + off * 16'h0040;
        end else if (id == 5'd21) begin
            return 16'h2820;
        end
        return 16'h0000;
    endfunction

    // Pixel count (w*h) of a map; ids outside the table return 0.
    function automatic logic [IDX_W-1:0] map_len(input logic [ID_W-1:0] id);
        if (id == 5'd0)       return 10'd784;
        else if (id <= 5'd16) return 10'd576;
        else if (id <= 5'd20) return 10'd64;
        else if (id == 5'd21) return 10'd10;
        return 10'd0;
    endfunction

endpackage

// File: rtl/fmap_capture_if.sv
// Pixel stream from the CNN into the capture block: AXI-stream style beat
// with start-of-map (tuser), end-of-map (tlast) and the map id.
interface fmap_capture_if;
    import fmap_pkg::*;

    logic [7:0]      s_tdata;
    logic            s_tvalid;
    logic            s_tready;
    logic            s_tuser;
    logic            s_tlast;
    logic [ID_W-1:0] s_map_id;

    modport master (
        output s_tdata, s_tvalid, s_tuser, s_tlast, s_map_id,
        input  s_tready
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tuser, s_tlast, s_map_id,
        output s_tready
    );
endinterface

// File: rtl/fmap_stats.sv
// Per-map min/max register file. An entry is re-seeded by the first pixel
// of a map and then tracks every later pixel written to that map.
// Readback is combinational; unwritten entries read FF/00.
module fmap_stats
    import fmap_pkg::*;
#(
    parameter int NM = 22
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en_i,
    input  logic            wr_first_i,
    input  logic [ID_W-1:0] wr_id_i,
    input  logic [7:0]      wr_data_i,
    input  logic [ID_W-1:0] rd_sel_i,
    output logic [7:0]      rd_min_o,
    output logic [7:0]      rd_max_o
);

    logic [7:0] min_q [NM];
    logic [7:0] max_q [NM];

    // Seed on the first pixel of a map, then fold in each further pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NM; i++) begin
                min_q[i] <= 8'hFF;
                max_q[i] <= 8'h00;
            end
        end else if (wr_en_i && (wr_id_i < ID_W'(NM))) begin
            if (wr_first_i) begin
                min_q[wr_id_i] <= wr_data_i;
                max_q[wr_id_i] <= wr_data_i;
            end else begin
                if (wr_data_i < min_q[wr_id_i]) min_q[wr_id_i] <= wr_data_i;
                if (wr_data_i > max_q[wr_id_i]) max_q[wr_id_i] <= wr_data_i;
            end
        end
    end

    // Readback of the selected entry; out-of-range selects read as empty.
    always_comb begin
        rd_min_o = 8'hFF;
        rd_max_o = 8'h00;
        if (rd_sel_i < ID_W'(NM)) begin
            rd_min_o = min_q[rd_sel_i];
            rd_max_o = max_q[rd_sel_i];
        end
    end

endmodule

// File: rtl/fmap_capture.sv
// Feature-map capture: writes the CNN pixel stream into the display BRAM at
// base(map) + idx, checks framing, pulses map_done / err_len / err_sync and
// stalls while the display side holds freeze.
// Optional build macro FMAP_STATS_EN adds the per-map min/max register file;
// without it stat_min/stat_max read constant 00/FF.
module fmap_capture
    import fmap_pkg::*;
#(
    parameter int NM     = 22,
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    fmap_capture_if.slave     s,
    input  logic              freeze,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_wdata,
    output logic              map_done,
    output logic [ID_W-1:0]   done_id,
    output logic              err_len,
    output logic              err_sync,
    input  logic [ID_W-1:0]   stat_sel,
    output logic [7:0]        stat_min,
    output logic [7:0]        stat_max
);

    capture_state_t    state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  len_q;
    logic [ADDR_W-1:0] base_q;
    logic [ID_W-1:0]   cur_id_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic              done_q;
    logic [ID_W-1:0]   done_id_q;
    logic              err_len_q;
    logic              err_sync_q;
`ifdef FMAP_STATS_EN
    logic              first_q;
`endif

    logic              acc;
    logic              id_ok;
    logic [ADDR_W-1:0] start_base;
    logic [IDX_W-1:0]  start_len;

    // Freeze is the only back-pressure source; it stalls in every state.
    assign s.s_tready = !freeze;
    assign acc        = s.s_tvalid & !freeze;
    assign id_ok      = s.s_map_id < ID_W'(NM);
    assign start_base = ADDR_W'(map_base(s.s_map_id));
    assign start_len  = IDX_W'(map_len(s.s_map_id));

    // Capture FSM with registered BRAM write port and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            base_q     <= '0;
            cur_id_q   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
            err_len_q  <= 1'b0;
            err_sync_q <= 1'b0;
`ifdef FMAP_STATS_EN
            first_q    <= 1'b0;
`endif
        end else begin
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_len_q  <= 1'b0;
            err_sync_q <= 1'b0;
`ifdef FMAP_STATS_EN
            first_q    <= 1'b0;
`endif
            if (acc) begin
                if (s.s_tuser) begin
                    // A start beat abandons any map still in progress.
                    if (state_q == CAPTURE) err_len_q <= 1'b1;
                    if (id_ok) begin
                        cur_id_q <= s.s_map_id;
                        base_q   <= start_base;
                        len_q    <= start_len;
                        idx_q    <= IDX_W'(1);
                        we_q     <= 1'b1;
                        addr_q   <= start_base;
                        wdata_q  <= s.s_tdata;
`ifdef FMAP_STATS_EN
                        first_q  <= 1'b1;
`endif
                        if (start_len == IDX_W'(1)) begin
                            if (s.s_tlast) begin
                                done_q    <= 1'b1;
                                done_id_q <= s.s_map_id;
                                state_q   <= IDLE;
                            end else begin
                                err_len_q <= 1'b1;
                                state_q   <= DRAIN;
                            end
                        end else if (s.s_tlast) begin
                            err_len_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            state_q <= CAPTURE;
                        end
                    end else begin
                        // Unknown map: swallow it up to its tlast.
                        err_sync_q <= 1'b1;
                        state_q    <= s.s_tlast ? IDLE : DRAIN;
                    end
                end else begin
                    case (state_q)
                        IDLE: begin
                            err_sync_q <= 1'b1;
                        end
                        CAPTURE: begin
                            we_q    <= 1'b1;
                            addr_q  <= base_q + ADDR_W'(idx_q);
                            wdata_q <= s.s_tdata;
                            idx_q   <= idx_q + IDX_W'(1);
                            if (idx_q == len_q - IDX_W'(1)) begin
                                if (s.s_tlast) begin
                                    done_q    <= 1'b1;
                                    done_id_q <= cur_id_q;
                                    state_q   <= IDLE;
                                end else begin
                                    err_len_q <= 1'b1;
                                    state_q   <= DRAIN;
                                end
                            end else if (s.s_tlast) begin
                                err_len_q <= 1'b1;
                                state_q   <= IDLE;
                            end
                        end
                        DRAIN: begin
                            if (s.s_tlast) state_q <= IDLE;
                        end
                        default: begin
                            state_q <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;
    assign map_done   = done_q;
    assign done_id    = done_id_q;
    assign err_len    = err_len_q;
    assign err_sync   = err_sync_q;

`ifdef FMAP_STATS_EN
    fmap_stats #(.NM(NM)) u_stats (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (we_q),
        .wr_first_i (first_q),
        .wr_id_i    (cur_id_q),
        .wr_data_i  (wdata_q),
        .rd_sel_i   (stat_sel),
        .rd_min_o   (stat_min),
        .rd_max_o   (stat_max)
    );
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_min        = 8'h00;
    assign stat_max        = 8'hFF;
`endif

endmodule
